// File: rtl/mips_bus_pkg.sv
// Shared types and default widths for the two-master CPU memory bus arbiter.
package mips_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  function automatic logic [1:0] grant_of(input arb_state_t s);
    case (s)
      GNT0:    grant_of = 2'b01;
      GNT1:    grant_of = 2'b10;
      default: grant_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_core.sv
// Round-robin grant state machine: holds the owner for a whole transfer and
// hands over to the other master on completion without an idle bubble.
module bus_rr_arbiter_core
  import mips_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       xfer_done,
  output logic [1:0] grant
);

  arb_state_t state;
  arb_state_t state_next;
  logic       last;
  logic       last_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
      grant <= 2'b00;
    end else begin
      state <= state_next;
      last  <= last_next;
      grant <= grant_of(state_next);
    end
  end

  // A pending transfer implies the owner is requesting, so only an idle owner can lose the bus early.
  always_comb begin
    state_next = state;
    last_next  = last;
    case (state)
      IDLE: begin
        if (req[0] && req[1]) state_next = last ? GNT0 : GNT1;
        else if (req[0])      state_next = GNT0;
        else if (req[1])      state_next = GNT1;
      end
      GNT0: begin
        if (xfer_done) begin
          if (req[1]) state_next = GNT1;
        end else if (!req[0] && req[1]) begin
          state_next = GNT1;
        end
      end
      GNT1: begin
        if (xfer_done) begin
          if (req[0]) state_next = GNT0;
        end else if (!req[1] && req[0]) begin
          state_next = GNT0;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state_next == GNT0)      last_next = 1'b0;
    else if (state_next == GNT1) last_next = 1'b1;
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master/one-slave bus arbiter with registered round-robin grant.
// Optional performance counters are built when ARB_PERF_EN is defined.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_waitrequest,
  output logic [1:0]        grant
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]       perf_xfer0,
  output logic [31:0]       perf_xfer1,
  output logic [31:0]       perf_conflict
`endif
);

  logic [1:0] req;
  logic [1:0] owner;
  logic       xfer_done;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  // Reset forces the slave side idle in the same cycle, abandoning any in-flight access.
  assign owner     = reset ? 2'b00 : grant;
  assign xfer_done = (s_read | s_write) & ~s_waitrequest;

  bus_rr_arbiter_core u_core (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .xfer_done (xfer_done),
    .grant     (grant)
  );

  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = s_readdata;
    m1_readdata    = s_readdata;
    if (owner[0]) begin
      s_address      = m0_address;
      s_read         = m0_read;
      s_write        = m0_write;
      s_writedata    = m0_writedata;
      s_byteenable   = m0_byteenable;
      m0_waitrequest = s_waitrequest;
    end else if (owner[1]) begin
      s_address      = m1_address;
      s_read         = m1_read;
      s_write        = m1_write;
      s_writedata    = m1_writedata;
      s_byteenable   = m1_byteenable;
      m1_waitrequest = s_waitrequest;
    end
  end

`ifdef ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_xfer0    <= 32'd0;
      perf_xfer1    <= 32'd0;
      perf_conflict <= 32'd0;
    end else begin
      if (xfer_done && owner[0]) perf_xfer0 <= perf_xfer0 + 32'd1;
      if (xfer_done && owner[1]) perf_xfer1 <= perf_xfer1 + 32'd1;
      if (req[0] && req[1])      perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench for mips_bus_arbiter with a wait-state memory slave model.
// Define ARB_PERF_EN to also check the performance counters.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address, s_address;
  logic        m0_read, m0_write, m1_read, m1_write, s_read, s_write;
  logic [31:0] m0_writedata, m1_writedata, s_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic [31:0] m0_readdata, m1_readdata, s_readdata;
  logic        m0_waitrequest, m1_waitrequest, s_waitrequest;
  logic [1:0]  grant;
`ifdef ARB_PERF_EN
  logic [31:0] perf_xfer0, perf_xfer1, perf_conflict;
`endif

  always #5 clk = ~clk;

  mips_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(grant)
`ifdef ARB_PERF_EN
    , .perf_xfer0(perf_xfer0), .perf_xfer1(perf_xfer1), .perf_conflict(perf_conflict)
`endif
  );

  int total = 0;
  int bad = 0;
  int wait_n = 0;
  int conf_cnt = 0;

  typedef struct {
    int          m;
    bit          rd;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic push(input int m, input bit rd, input logic [31:0] d);
    exp_t e;
    e.m = m; e.rd = rd; e.data = d;
    exp_q.push_back(e);
  endtask

  // Memory slave: each access stalls wait_n cycles before completing.
  logic [31:0] mem [0:15];
  int          scnt = 0;
  logic        load_en = 1'b0;
  logic [3:0]  load_idx = 4'd0;
  logic [31:0] load_val = 32'd0;

  assign s_waitrequest = (s_read || s_write) && (scnt < wait_n);
  assign s_readdata    = mem[s_address[5:2]];

  always @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_val;
    if (reset || !(s_read || s_write)) scnt <= 0;
    else if (s_waitrequest) scnt <= scnt + 1;
    else begin
      scnt <= 0;
      if (s_write)
        for (int b = 0; b < 4; b++)
          if (s_byteenable[b]) mem[s_address[5:2]][8*b +: 8] <= s_writedata[8*b +: 8];
    end
  end

  // Monitor: bus invariants, completion scoreboard and same-edge hand-off.
  bit   prev_done = 1'b0;
  int   prev_m = 0;
  bit   prev_other_req = 1'b0;

  always @(negedge clk) begin
    bit   done_now;
    int   dm;
    exp_t e;
    done_now = 1'b0;
    dm = 0;
    if (!reset) begin
      if (grant == 2'b00) begin
        check("idle_cmd", 32'({s_read, s_write}), 32'd0);
        check("idle_wait", 32'({m0_waitrequest, m1_waitrequest}), 32'd3);
      end
      if (grant != 2'b01) check("m0_wait_nonowner", 32'(m0_waitrequest), 32'd1);
      if (grant != 2'b10) check("m1_wait_nonowner", 32'(m1_waitrequest), 32'd1);
      if (prev_done && prev_other_req)
        check("handoff_grant", 32'(grant), (prev_m == 0) ? 32'd2 : 32'd1);
      if (grant == 2'b01 && (m0_read || m0_write) && !m0_waitrequest) begin
        done_now = 1'b1; dm = 0;
      end
      if (grant == 2'b10 && (m1_read || m1_write) && !m1_waitrequest) begin
        done_now = 1'b1; dm = 1;
      end
      if (done_now) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_xfer: got completion from m%0d expected none", dm);
        end else begin
          e = exp_q.pop_front();
          check("xfer_master", 32'(dm), 32'(e.m));
          if (e.rd) check("readdata", (dm == 0) ? m0_readdata : m1_readdata, e.data);
        end
      end
      if (m0_read || m0_write) begin
        if (m1_read || m1_write) conf_cnt++;
      end
    end else begin
      conf_cnt = 0;
    end
    prev_done      = done_now;
    prev_m         = dm;
    prev_other_req = (dm == 0) ? (m1_read || m1_write) : (m0_read || m0_write);
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic load(input int idx, input logic [31:0] v);
    load_idx = 4'(idx); load_val = v; load_en = 1'b1;
    sync();
    load_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sync();
    reset = 1'b0;
  endtask

  task automatic drive(input int m, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  task automatic wait_done(input int m);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      done = (m == 0) ? !m0_waitrequest : !m1_waitrequest;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout_m%0d: got no completion expected one within 300 cycles", m);
    end
    sync();
  endtask

  task automatic xfer(input int m, input bit rd, input logic [31:0] a, input logic [31:0] d);
    drive(m, rd, !rd, a, d, 4'hF);
    wait_done(m);
    drive(m, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
  endtask

  task automatic read_burst(input int m, input int base_idx);
    for (int i = 0; i < 4; i++) begin
      drive(m, 1'b1, 1'b0, 32'((base_idx + i) * 4), 32'd0, 4'hF);
      wait_done(m);
    end
    drive(m, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    sync();
    load(0, 32'h8C02_0004);
    load(4, 32'h0000_0000);
    load(6, 32'h600D_F00D);
    for (int k = 8; k < 16; k++) load(k, 32'hA500_0000 | 32'(k));
    do_reset();

    // Reset then idle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_cmd", 32'({s_read, s_write}), 32'd0);
      check("rst_wait", 32'({m0_waitrequest, m1_waitrequest}), 32'd3);
    end

    // Single m0 read with two wait states.
    sync();
    wait_n = 2;
    push(0, 1'b1, 32'h8C02_0004);
    fork
      xfer(0, 1'b1, 32'hBFC0_0000, 32'd0);
      begin
        @(negedge clk); check("lat_idle", 32'(grant), 32'd0);
        @(negedge clk); check("lat_grant", 32'(grant), 32'd1);
        check("lat_addr", s_address, 32'hBFC0_0000);
      end
    join

    // Simultaneous write/read after reset: m0 first, m1 reads the written word.
    do_reset();
    wait_n = 1;
    push(0, 1'b0, 32'd0);
    push(1, 1'b1, 32'hDEAD_BEEF);
    fork
      xfer(0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
      xfer(1, 1'b1, 32'h0000_0010, 32'd0);
    join

    // Fairness: four back-to-back reads from each master alternate.
    do_reset();
    wait_n = 1;
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b1, 32'hA500_0000 | 32'(8 + i));
      push(1, 1'b1, 32'hA500_0000 | 32'(12 + i));
    end
    fork
      read_burst(0, 8);
      read_burst(1, 12);
    join
    sync();
    sync();
`ifdef ARB_PERF_EN
    @(negedge clk);
    check("perf_xfer0", perf_xfer0, 32'd4);
    check("perf_xfer1", perf_xfer1, 32'd4);
    check("perf_conflict", perf_conflict, 32'(conf_cnt));
    sync();
`endif

    // Reset while m1 write is stalled; m0 then wins the first tie.
    do_reset();
    wait_n = 100;
    push(0, 1'b1, 32'h600D_F00D);
    push(1, 1'b0, 32'd0);
    drive(1, 1'b0, 1'b1, 32'h0000_0014, 32'hCAFE_F00D, 4'hF);
    @(negedge clk); check("stall_idle", 32'(grant), 32'd0);
    @(negedge clk); check("stall_grant", 32'(grant), 32'd2);
    check("stall_write", 32'(s_write), 32'd1);
    sync();
    drive(0, 1'b1, 1'b0, 32'h0000_0018, 32'd0, 4'hF);
    @(negedge clk); check("stall_hold", 32'(grant), 32'd2);
    sync();
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_write", 32'(s_write), 32'd0);
    check("rst_mid_wait", 32'(m1_waitrequest), 32'd1);
    sync();
    reset = 1'b0;
    wait_n = 1;
    @(negedge clk);
    check("post_rst_grant", 32'(grant), 32'd0);
    check("post_rst_write", 32'(s_write), 32'd0);
    @(negedge clk); check("post_rst_tie", 32'(grant), 32'd1);
    wait_done(0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    wait_done(1);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);

    sync();
    sync();
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
